pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the pipelined core's fetch stage, successor to the plain load-only PC register. Computes the next PC internally from a sequential increment, branch/jump redirects and a return-address stack (RAS). It also owns a RUN/HALTED state machine, so halt and resume are clean and need no PC rewind. Output feeds instruction-memory addressing; redirect inputs come from ID/EX.

## Interface
- NBITS, 32, PC width; all PC arithmetic is modulo 2^NBITS
- STEP, 1, sequential increment (word-addressed)
- RESET_PC, 0, PC value after reset
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2)

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  global advance enable; low = hold everything
- i_stall  in  1  hazard stall; PC and RAS hold
- i_halt  in  1  halt instruction decoded
- i_resume  in  1  leave HALTED
- i_step  in  1  single-step request (see Configuration)
- i_branch_taken  in  1  EX-stage branch redirect
- i_branch_target  in  NBITS  branch target
- i_jump  in  1  ID-stage jump redirect
- i_call  in  1  qualifies i_jump: also push return address
- i_return  in  1  ID-stage return: pop RAS
- i_jump_target  in  NBITS  jump target; fallback target for return on empty RAS
- i_clear_flags  in  1  clear sticky RAS flags
- o_pc  out  NBITS  current PC (registered)
- o_halted  out  1  state is HALTED
- o_ras_full, o_ras_empty  out  1  RAS occupancy
- o_ras_overflow, o_ras_underflow  out  1  sticky error flags

## Operation
- States: RUN, HALTED (plus STEP when configured). Reset → RUN, o_pc=RESET_PC, RAS empty, all flags 0, o_halted=0, o_ras_empty=1.
- An "update" occurs in RUN when i_enable=1 and i_stall=0. Priority, highest first: i_reset > i_halt > hold (i_enable=0 or i_stall=1) > i_branch_taken > i_jump (incl. call) > i_return > sequential (o_pc+STEP).
- i_halt in RUN with i_enable=1 (stall irrelevant): PC holds, → HALTED. Redirects in that cycle are discarded and the RAS is unchanged.
- HALTED: PC and RAS frozen. All redirect inputs are ignored. i_resume=1 → RUN; o_pc first changes on the edge after the one that leaves HALTED.
- Branch: o_pc←i_branch_target; RAS untouched even if jump/call/return are also asserted.
- Jump: o_pc←i_jump_target. With i_call, push o_pc+STEP. Push when full: the oldest entry is overwritten (circular), depth stays RAS_DEPTH, o_ras_overflow←1.
- Return (no branch or jump that cycle): pop top into o_pc. If the RAS is empty, o_pc←i_jump_target, o_ras_underflow←1, and the pointer is unchanged. A return asserted together with a jump is ignored.
- Wrap-around: PC arithmetic wraps, e.g. 2^NBITS−1 + 1 → 0; no flag.
- i_clear_flags clears both sticky flags. A same-cycle set event wins (flag stays 1).

## Timing
- Inputs are sampled at the rising edge; o_pc shows the chosen value one cycle later. Redirect latency is 1 cycle.
- o_halted is registered: 1 in the cycle after i_halt is accepted, 0 in the cycle after i_resume.
- RAS push/pop and full/empty/flag outputs update on the same edge as o_pc.
- A mid-operation reset overrides everything on the next edge, including halt and step.

## Configuration
- PC_SINGLE_STEP_EN defined: i_step=1 in HALTED → STEP for one cycle. During that cycle exactly one normal update is performed with the normal priority (i_stall still holds the step pending; i_halt re-halts immediately). Then → HALTED. i_resume wins over i_step.
- Not defined: the STEP state is absent, i_step is ignored, and HALTED exits only via i_resume or reset.

## Test plan
- Reset with RESET_PC=0x100, STEP=1, 3 idle-free cycles → o_pc 0x100, 0x101, 0x102, 0x103; RAS empty, flags 0.
- Same cycle: i_branch_taken (0x40) + i_jump (0x80) + i_call → next o_pc=0x40, RAS stays empty; hold, then call at PC 0x10 to 0x80 → RAS top 0x11; return → o_pc=0x11.
- RAS_DEPTH=4: five calls → o_ras_full=1, o_ras_overflow=1; five returns → first four pop newest-first, fifth goes to i_jump_target with o_ras_underflow=1; i_clear_flags → both flags 0.
- i_halt at PC 0x20 with i_stall=1 → o_pc stays 0x20, o_halted=1 next cycle; i_resume → o_pc 0x21 on the second edge after resume.
- Wrap: NBITS=8, PC=0xFF → 0x00; i_enable=0 for 3 cycles → PC frozen; i_reset mid-halt → RUN, o_pc=RESET_PC.
- With PC_SINGLE_STEP_EN: halted at 0x30, i_step pulse → o_pc=0x31 and back in HALTED; a second pulse with i_stall=1 held for 2 cycles → o_pc stays 0x31 until the stall drops, then 0x32.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: sequential/branch/jump/return next-PC selection, circular
// return-address stack, RUN/HALTED control. Optional STEP state via PC_SINGLE_STEP_EN.
module pc_unit #(
  parameter int NBITS     = 32,
  parameter int STEP      = 1,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_stall,
  input  logic             i_halt,
  input  logic             i_resume,
  input  logic             i_step,
  input  logic             i_branch_taken,
  input  logic [NBITS-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic             i_call,
  input  logic             i_return,
  input  logic [NBITS-1:0] i_jump_target,
  input  logic             i_clear_flags,
  output logic [NBITS-1:0] o_pc,
  output logic             o_halted,
  output logic             o_ras_full,
  output logic             o_ras_empty,
  output logic             o_ras_overflow,
  output logic             o_ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [NBITS-1:0] STEP_V     = NBITS'(STEP);
  localparam logic [NBITS-1:0] RESET_PC_V = NBITS'(RESET_PC);
  localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W + 1)'(RAS_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_STEP} state_e;

  state_e             state_q, state_d;
  logic [NBITS-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]   sp_q, sp_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [NBITS-1:0]   ras_q [RAS_DEPTH];

  logic               do_update;
  logic               ras_full, ras_empty;
  logic               push_en;
  logic [NBITS-1:0]   push_val;
  logic               set_ovf, set_unf;
  logic [PTR_W-1:0]   top_idx;

`ifndef PC_SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = i_step;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC_V;
      sp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge i_clk) begin
    if (!i_reset && push_en) ras_q[sp_q] <= push_val;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (i_enable && i_halt) state_d = ST_HALTED;
      ST_HALTED: begin
        if (i_enable) begin
          if (i_resume) state_d = ST_RUN;
`ifdef PC_SINGLE_STEP_EN
          else if (i_step) state_d = ST_STEP;
`endif
        end
      end
      ST_STEP:   if (i_enable && (i_halt || !i_stall)) state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    do_update = i_enable && !i_halt && !i_stall &&
                ((state_q == ST_RUN) || (state_q == ST_STEP));
    ras_full  = (cnt_q == FULL_CNT);
    ras_empty = (cnt_q == '0);
    top_idx   = sp_q - PTR_W'(1);
  end

  // Next-PC selection: branch > jump/call > return > sequential.
  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    push_en  = 1'b0;
    push_val = pc_q + STEP_V;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (do_update) begin
      if (i_branch_taken) begin
        pc_d = i_branch_target;
      end else if (i_jump) begin
        pc_d = i_jump_target;
        if (i_call) begin
          push_en = 1'b1;
          sp_d    = sp_q + PTR_W'(1);
          if (ras_full) set_ovf = 1'b1;
          else          cnt_d   = cnt_q + 1'b1;
        end
      end else if (i_return) begin
        if (ras_empty) begin
          pc_d    = i_jump_target;
          set_unf = 1'b1;
        end else begin
          pc_d  = ras_q[top_idx];
          sp_d  = top_idx;
          cnt_d = cnt_q - 1'b1;
        end
      end else begin
        pc_d = pc_q + STEP_V;
      end
    end
    ovf_d = (ovf_q & ~i_clear_flags) | set_ovf;
    unf_d = (unf_q & ~i_clear_flags) | set_unf;
  end

  always_comb begin
    o_pc            = pc_q;
    o_halted        = (state_q == ST_HALTED);
    o_ras_full      = ras_full;
    o_ras_empty     = ras_empty;
    o_ras_overflow  = ovf_q;
    o_ras_underflow = unf_q;
  end

endmodule
